combat_referee: RTL and testbench

Per-frame hit referee for the saber duel. Sits directly upstream of the display stage: consumes both sabers' tip positions and states plus both players' bounding boxes, and produces the health counters, hit pulses and game-over/winner flags that the display stage renders. Evaluates collisions once per video frame on the new-frame pulse, so health changes are frame-synchronous and never tear mid-frame.

---
 rtl/combat_referee.sv | 218 +++++++++++++++++++++
 tb/tb_combat_referee.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/combat_referee.sv
// combat_referee: per-frame hit referee for the saber duel.
// Snapshots both sabers and boxes on the new-frame pulse, evaluates hits on the
// following edge, and keeps health, invulnerability cooldowns and the match state.
`timescale 1ns/1ps

module combat_referee #(
    parameter int START_HEALTH = 5,
    parameter int IFRAMES      = 60
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        nf_in,
    input  logic        start_in,
    input  logic [11:0] player_saber_x_in,
    input  logic [11:0] opponent_saber_x_in,
    input  logic [10:0] player_saber_y_in,
    input  logic [10:0] opponent_saber_y_in,
    input  logic [1:0]  player_saber_state_in,
    input  logic [1:0]  opponent_saber_state_in,
    input  logic [11:0] player_box_x_in,
    input  logic [11:0] player_box_xmax_in,
    input  logic [11:0] opponent_box_x_in,
    input  logic [11:0] opponent_box_xmax_in,
    input  logic [10:0] player_box_y_in,
    input  logic [10:0] player_box_ymax_in,
    input  logic [10:0] opponent_box_y_in,
    input  logic [10:0] opponent_box_ymax_in,
    output logic [2:0]  player_health_out,
    output logic [2:0]  opponent_health_out,
    output logic        player_hit_out,
    output logic        opponent_hit_out,
    output logic        game_over_out,
    output logic [1:0]  winner_out,
    output logic [1:0]  state_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FIGHT = 2'b01,
        OVER  = 2'b10
    } state_t;

    localparam logic [2:0] START_H  = 3'(START_HEALTH);
    localparam logic [7:0] IFR      = 8'(IFRAMES);
    localparam logic [1:0] ST_BLOCK = 2'd2;
    localparam logic [1:0] ST_HEAVY = 2'd3;

    state_t      state_q, state_d;
    logic [2:0]  p_health_q, p_health_d;
    logic [2:0]  o_health_q, o_health_d;
    logic [7:0]  p_cool_q, p_cool_d;
    logic [7:0]  o_cool_q, o_cool_d;
    logic        p_hit_q, p_hit_d;
    logic        o_hit_q, o_hit_d;
    logic [1:0]  winner_q, winner_d;
    logic        game_over_q, game_over_d;

    // Frame snapshot: evaluation only ever looks at these, never the live inputs.
    logic        pending;
    logic [11:0] snap_p_x, snap_o_x;
    logic [10:0] snap_p_y, snap_o_y;
    logic [1:0]  snap_p_st, snap_o_st;
    logic [11:0] snap_pb_x, snap_pb_xmax, snap_ob_x, snap_ob_xmax;
    logic [10:0] snap_pb_y, snap_pb_ymax, snap_ob_y, snap_ob_ymax;

    logic        capture;
    logic        evaluate;
    logic        p_attacking, o_attacking;
    logic        p_tip_in_obox, o_tip_in_pbox;
    logic        hit_on_p, hit_on_o;
    logic [2:0]  dmg_to_p, dmg_to_o;
    logic [2:0]  p_health_after, o_health_after;
    logic [7:0]  p_cool_after, o_cool_after;

    assign capture  = nf_in && (state_q == FIGHT);
    assign evaluate = pending && (state_q == FIGHT);

    // Attack states are 1 (light) and 3 (heavy): both have bit 0 set.
    assign p_attacking = snap_p_st[0];
    assign o_attacking = snap_o_st[0];

    // Inclusive bounds; an inverted box admits no tip position at all.
    assign p_tip_in_obox = (snap_p_x >= snap_ob_x) && (snap_p_x <= snap_ob_xmax) &&
                           (snap_p_y >= snap_ob_y) && (snap_p_y <= snap_ob_ymax);
    assign o_tip_in_pbox = (snap_o_x >= snap_pb_x) && (snap_o_x <= snap_pb_xmax) &&
                           (snap_o_y >= snap_pb_y) && (snap_o_y <= snap_pb_ymax);

    assign hit_on_o = p_attacking && p_tip_in_obox && (snap_o_st != ST_BLOCK) && (o_cool_q == 8'd0);
    assign hit_on_p = o_attacking && o_tip_in_pbox && (snap_p_st != ST_BLOCK) && (p_cool_q == 8'd0);

    assign dmg_to_o = (snap_p_st == ST_HEAVY) ? 3'd2 : 3'd1;
    assign dmg_to_p = (snap_o_st == ST_HEAVY) ? 3'd2 : 3'd1;

    // Saturate at zero so a heavy hit on 1 health never wraps to 7.
    assign o_health_after = (o_health_q > dmg_to_o) ? (o_health_q - dmg_to_o) : 3'd0;
    assign p_health_after = (p_health_q > dmg_to_p) ? (p_health_q - dmg_to_p) : 3'd0;

    // A hit reloads the window; otherwise the window counts down using the pre-decrement value.
    assign o_cool_after = hit_on_o ? IFR : ((o_cool_q != 8'd0) ? (o_cool_q - 8'd1) : 8'd0);
    assign p_cool_after = hit_on_p ? IFR : ((p_cool_q != 8'd0) ? (p_cool_q - 8'd1) : 8'd0);

    // Capture the frame inputs on nf_in during a fight and flag them for evaluation next edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pending      <= 1'b0;
            snap_p_x     <= '0;
            snap_p_y     <= '0;
            snap_p_st    <= '0;
            snap_o_x     <= '0;
            snap_o_y     <= '0;
            snap_o_st    <= '0;
            snap_pb_x    <= '0;
            snap_pb_xmax <= '0;
            snap_pb_y    <= '0;
            snap_pb_ymax <= '0;
            snap_ob_x    <= '0;
            snap_ob_xmax <= '0;
            snap_ob_y    <= '0;
            snap_ob_ymax <= '0;
        end else begin
            pending <= capture;
            if (capture) begin
                snap_p_x     <= player_saber_x_in;
                snap_p_y     <= player_saber_y_in;
                snap_p_st    <= player_saber_state_in;
                snap_o_x     <= opponent_saber_x_in;
                snap_o_y     <= opponent_saber_y_in;
                snap_o_st    <= opponent_saber_state_in;
                snap_pb_x    <= player_box_x_in;
                snap_pb_xmax <= player_box_xmax_in;
                snap_pb_y    <= player_box_y_in;
                snap_pb_ymax <= player_box_ymax_in;
                snap_ob_x    <= opponent_box_x_in;
                snap_ob_xmax <= opponent_box_xmax_in;
                snap_ob_y    <= opponent_box_y_in;
                snap_ob_ymax <= opponent_box_ymax_in;
            end
        end
    end

    // Next-state and next-output logic for the match FSM.
    always_comb begin
        state_d    = state_q;
        p_health_d = p_health_q;
        o_health_d = o_health_q;
        p_cool_d   = p_cool_q;
        o_cool_d   = o_cool_q;
        p_hit_d    = 1'b0;
        o_hit_d    = 1'b0;
        winner_d   = winner_q;

        case (state_q)
            IDLE, OVER: begin
                if (start_in) begin
                    state_d    = FIGHT;
                    p_health_d = START_H;
                    o_health_d = START_H;
                    p_cool_d   = 8'd0;
                    o_cool_d   = 8'd0;
                    winner_d   = 2'b00;
                end
            end
            FIGHT: begin
                if (evaluate) begin
                    p_hit_d    = hit_on_p;
                    o_hit_d    = hit_on_o;
                    p_health_d = hit_on_p ? p_health_after : p_health_q;
                    o_health_d = hit_on_o ? o_health_after : o_health_q;
                    p_cool_d   = p_cool_after;
                    o_cool_d   = o_cool_after;
                    if ((p_health_d == 3'd0) || (o_health_d == 3'd0)) begin
                        state_d  = OVER;
                        winner_d = {p_health_d == 3'd0, o_health_d == 3'd0};
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        game_over_d = (state_d == OVER);
    end

    // Match state register; all outputs come straight from here.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            p_health_q  <= START_H;
            o_health_q  <= START_H;
            p_cool_q    <= 8'd0;
            o_cool_q    <= 8'd0;
            p_hit_q     <= 1'b0;
            o_hit_q     <= 1'b0;
            winner_q    <= 2'b00;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_health_q  <= p_health_d;
            o_health_q  <= o_health_d;
            p_cool_q    <= p_cool_d;
            o_cool_q    <= o_cool_d;
            p_hit_q     <= p_hit_d;
            o_hit_q     <= o_hit_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
        end
    end

    assign player_health_out   = p_health_q;
    assign opponent_health_out = o_health_q;
    assign player_hit_out      = p_hit_q;
    assign opponent_hit_out    = o_hit_q;
    assign game_over_out       = game_over_q;
    assign winner_out          = winner_q;
    assign state_out           = state_q;

endmodule

// File: tb/tb_combat_referee.sv
// Testbench for combat_referee: directed frames feed a scoreboard queue with
// cycle-tagged expectations; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_combat_referee;

    localparam int START_HEALTH = 5;
    localparam int IFRAMES      = 60;

    localparam int S_IDLE  = 0;
    localparam int S_FIGHT = 1;
    localparam int S_OVER  = 2;
    localparam int W_NONE   = 0;
    localparam int W_PLAYER = 1;
    localparam int W_OPP    = 2;
    localparam int W_DRAW   = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        nf_in;
    logic        start_in;
    logic [11:0] player_saber_x_in, opponent_saber_x_in;
    logic [10:0] player_saber_y_in, opponent_saber_y_in;
    logic [1:0]  player_saber_state_in, opponent_saber_state_in;
    logic [11:0] player_box_x_in, player_box_xmax_in, opponent_box_x_in, opponent_box_xmax_in;
    logic [10:0] player_box_y_in, player_box_ymax_in, opponent_box_y_in, opponent_box_ymax_in;
    logic [2:0]  player_health_out, opponent_health_out;
    logic        player_hit_out, opponent_hit_out, game_over_out;
    logic [1:0]  winner_out, state_out;

    combat_referee #(
        .START_HEALTH(START_HEALTH),
        .IFRAMES(IFRAMES)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .nf_in(nf_in),
        .start_in(start_in),
        .player_saber_x_in(player_saber_x_in),
        .opponent_saber_x_in(opponent_saber_x_in),
        .player_saber_y_in(player_saber_y_in),
        .opponent_saber_y_in(opponent_saber_y_in),
        .player_saber_state_in(player_saber_state_in),
        .opponent_saber_state_in(opponent_saber_state_in),
        .player_box_x_in(player_box_x_in),
        .player_box_xmax_in(player_box_xmax_in),
        .opponent_box_x_in(opponent_box_x_in),
        .opponent_box_xmax_in(opponent_box_xmax_in),
        .player_box_y_in(player_box_y_in),
        .player_box_ymax_in(player_box_ymax_in),
        .opponent_box_y_in(opponent_box_y_in),
        .opponent_box_ymax_in(opponent_box_ymax_in),
        .player_health_out(player_health_out),
        .opponent_health_out(opponent_health_out),
        .player_hit_out(player_hit_out),
        .opponent_hit_out(opponent_hit_out),
        .game_over_out(game_over_out),
        .winner_out(winner_out),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         due;
        logic [2:0] ph;
        logic [2:0] oh;
        logic       phit;
        logic       ohit;
        logic [1:0] st;
        logic [1:0] win;
        logic       go;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    // Expected outputs as they stand between frames, maintained from the hand-computed values.
    int last_ph  = START_HEALTH;
    int last_oh  = START_HEALTH;
    int last_st  = S_IDLE;
    int last_win = W_NONE;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic void push(input int due, input int ph, input int oh, input int phit,
                                 input int ohit, input int st, input int win, input string name);
        exp_t e;
        e.due  = due;
        e.ph   = 3'(ph);
        e.oh   = 3'(oh);
        e.phit = 1'(phit);
        e.ohit = 1'(ohit);
        e.st   = 2'(st);
        e.win  = 2'(win);
        e.go   = (st == S_OVER);
        e.name = name;
        sb.push_back(e);
    endfunction

    function automatic void remember(input int ph, input int oh, input int st, input int win);
        last_ph  = ph;
        last_oh  = oh;
        last_st  = st;
        last_win = win;
    endfunction

    // Monitor: compares every expectation whose cycle has come, away from the active edge.
    always @(negedge clk_in) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.due < cyc) begin
                errors++;
                $display("[TB] FAIL %s: check reached at cycle %0d, required cycle %0d", e.name, cyc, e.due);
            end else if ({player_health_out, opponent_health_out, player_hit_out, opponent_hit_out,
                          state_out, winner_out, game_over_out} !==
                         {e.ph, e.oh, e.phit, e.ohit, e.st, e.win, e.go}) begin
                errors++;
                $display("[TB] FAIL %s: got ph=%0d oh=%0d phit=%0b ohit=%0b state=%0b winner=%0b over=%0b, expected ph=%0d oh=%0d phit=%0b ohit=%0b state=%0b winner=%0b over=%0b",
                         e.name, player_health_out, opponent_health_out, player_hit_out, opponent_hit_out,
                         state_out, winner_out, game_over_out,
                         e.ph, e.oh, e.phit, e.ohit, e.st, e.win, e.go);
            end
        end
    end

    // One new-frame pulse: outputs unchanged between the capture and evaluation edges,
    // the result one cycle later, and the hit pulses gone the cycle after that.
    task automatic frame(input int ps, input int os, input int eph, input int eoh, input int ephit,
                         input int eohit, input int est, input int ewin, input string name);
        @(posedge clk_in);
        #1;
        player_saber_state_in   = 2'(ps);
        opponent_saber_state_in = 2'(os);
        nf_in = 1'b1;
        @(posedge clk_in);
        #1;
        nf_in = 1'b0;
        push(cyc,     last_ph, last_oh, 0, 0, last_st, last_win, {name, "/before"});
        push(cyc + 1, eph, eoh, ephit, eohit, est, ewin, name);
        push(cyc + 2, eph, eoh, 0, 0, est, ewin, {name, "/after"});
        remember(eph, eoh, est, ewin);
        repeat (2) @(posedge clk_in);
    endtask

    task automatic do_start(input int eph, input int eoh, input int est, input int ewin,
                            input string name);
        @(posedge clk_in);
        #1;
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        push(cyc, eph, eoh, 0, 0, est, ewin, name);
        remember(eph, eoh, est, ewin);
        @(posedge clk_in);
    endtask

    // start_in and nf_in together: the start wins and no frame is evaluated.
    task automatic start_with_nf(input int ps, input int os, input string name);
        @(posedge clk_in);
        #1;
        player_saber_state_in   = 2'(ps);
        opponent_saber_state_in = 2'(os);
        start_in = 1'b1;
        nf_in    = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        nf_in    = 1'b0;
        push(cyc,     START_HEALTH, START_HEALTH, 0, 0, S_FIGHT, W_NONE, name);
        push(cyc + 1, START_HEALTH, START_HEALTH, 0, 0, S_FIGHT, W_NONE, {name, "/no_eval"});
        remember(START_HEALTH, START_HEALTH, S_FIGHT, W_NONE);
        repeat (2) @(posedge clk_in);
    endtask

    // Two back-to-back frames: idle snapshot then a light attack; neither may be lost.
    task automatic frame_pair(input string name);
        @(posedge clk_in);
        #1;
        player_saber_state_in   = 2'd0;
        opponent_saber_state_in = 2'd0;
        nf_in = 1'b1;
        @(posedge clk_in);
        #1;
        player_saber_state_in = 2'd1;
        push(cyc + 1, 5, 5, 0, 0, S_FIGHT, W_NONE, {name, "/first"});
        @(posedge clk_in);
        #1;
        nf_in = 1'b0;
        push(cyc + 1, 5, 4, 0, 1, S_FIGHT, W_NONE, {name, "/second"});
        push(cyc + 2, 5, 4, 0, 0, S_FIGHT, W_NONE, {name, "/after"});
        remember(5, 4, S_FIGHT, W_NONE);
        repeat (3) @(posedge clk_in);
    endtask

    // Reset asserted between edges must take effect before the next clock edge.
    task automatic reset_mid(input string name);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        push(cyc, START_HEALTH, START_HEALTH, 0, 0, S_IDLE, W_NONE, name);
        remember(START_HEALTH, START_HEALTH, S_IDLE, W_NONE);
        @(posedge clk_in);
        #1;
        push(cyc, START_HEALTH, START_HEALTH, 0, 0, S_IDLE, W_NONE, {name, "/held"});
        rst_in = 1'b1;
        @(posedge clk_in);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in   = 1'b0;
        nf_in    = 1'b0;
        start_in = 1'b0;
        player_saber_x_in       = 12'd500;
        player_saber_y_in       = 11'd300;
        player_saber_state_in   = 2'd0;
        opponent_saber_x_in     = 12'd700;
        opponent_saber_y_in     = 11'd700;
        opponent_saber_state_in = 2'd0;
        player_box_x_in         = 12'd100;
        player_box_xmax_in      = 12'd200;
        player_box_y_in         = 11'd250;
        player_box_ymax_in      = 11'd400;
        opponent_box_x_in       = 12'd450;
        opponent_box_xmax_in    = 12'd550;
        opponent_box_y_in       = 11'd250;
        opponent_box_ymax_in    = 11'd400;

        @(posedge clk_in);
        #1;
        push(cyc, 5, 5, 0, 0, S_IDLE, W_NONE, "reset_values");
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        // New-frame pulses before any start are ignored.
        frame(1, 0, 5, 5, 0, 0, S_IDLE, W_NONE, "nf_in_idle");
        do_start(5, 5, S_FIGHT, W_NONE, "start");

        // Blocking opponent takes nothing for 10 frames, then a light hit lands.
        for (int i = 0; i < 10; i++) frame(1, 2, 5, 5, 0, 0, S_FIGHT, W_NONE, "blocked");
        frame(1, 0, 5, 4, 0, 1, S_FIGHT, W_NONE, "first_hit");
        do_start(5, 4, S_FIGHT, W_NONE, "start_in_fight_ignored");

        // Constant attacks: invulnerable for exactly IFRAMES frames, hit on the next one.
        for (int i = 0; i < IFRAMES; i++) frame(1, 0, 5, 4, 0, 0, S_FIGHT, W_NONE, "iframes_window");
        frame(1, 0, 5, 3, 0, 1, S_FIGHT, W_NONE, "hit_after_iframes");

        // Box boundaries, with the opponent attacking the player box (100,250)-(200,400).
        opponent_saber_x_in = 12'd201;
        opponent_saber_y_in = 11'd300;
        frame(0, 1, 5, 3, 0, 0, S_FIGHT, W_NONE, "tip_xmax_plus1");
        opponent_saber_x_in = 12'd200;
        opponent_saber_y_in = 11'd401;
        frame(0, 1, 5, 3, 0, 0, S_FIGHT, W_NONE, "tip_ymax_plus1");
        opponent_saber_x_in = 12'd150;
        opponent_saber_y_in = 11'd300;
        player_box_x_in     = 12'd200;
        player_box_xmax_in  = 12'd100;
        frame(0, 1, 5, 3, 0, 0, S_FIGHT, W_NONE, "inverted_x_box");
        player_box_x_in     = 12'd100;
        player_box_xmax_in  = 12'd200;
        player_box_y_in     = 11'd400;
        player_box_ymax_in  = 11'd250;
        frame(0, 1, 5, 3, 0, 0, S_FIGHT, W_NONE, "inverted_y_box");
        player_box_y_in     = 11'd250;
        player_box_ymax_in  = 11'd400;
        opponent_saber_x_in = 12'd200;
        opponent_saber_y_in = 11'd400;
        frame(0, 1, 4, 3, 1, 0, S_FIGHT, W_NONE, "tip_on_max_corner");
        opponent_saber_x_in = 12'd700;
        opponent_saber_y_in = 11'd700;

        // Heavy attacks take the opponent 3 -> 1 -> 0 (saturating, no wrap to 7).
        for (int i = 0; i < IFRAMES; i++) frame(0, 0, 4, 3, 0, 0, S_FIGHT, W_NONE, "recover_a");
        frame(3, 0, 4, 1, 0, 1, S_FIGHT, W_NONE, "heavy_hit");
        for (int i = 0; i < IFRAMES; i++) frame(0, 0, 4, 1, 0, 0, S_FIGHT, W_NONE, "recover_b");
        frame(3, 0, 4, 0, 0, 1, S_OVER, W_PLAYER, "heavy_kill");
        frame(3, 0, 4, 0, 0, 0, S_OVER, W_PLAYER, "nf_in_over");

        // Restart with start and nf together, then mutual hits down to a draw.
        opponent_saber_x_in = 12'd150;
        opponent_saber_y_in = 11'd300;
        start_with_nf(1, 1, "start_wins_over_nf");
        frame(3, 3, 3, 3, 1, 1, S_FIGHT, W_NONE, "mutual_heavy");
        for (int i = 0; i < IFRAMES; i++) frame(0, 0, 3, 3, 0, 0, S_FIGHT, W_NONE, "recover_c");
        frame(3, 3, 1, 1, 1, 1, S_FIGHT, W_NONE, "mutual_heavy2");
        for (int i = 0; i < IFRAMES; i++) frame(0, 0, 1, 1, 0, 0, S_FIGHT, W_NONE, "recover_d");
        frame(1, 1, 0, 0, 1, 1, S_OVER, W_DRAW, "mutual_final");

        // Back-to-back frames, then a reset while the opponent cooldown is running.
        do_start(5, 5, S_FIGHT, W_NONE, "restart");
        frame_pair("back_to_back");
        reset_mid("reset_mid_fight");
        frame(1, 0, 5, 5, 0, 0, S_IDLE, W_NONE, "nf_before_start");
        do_start(5, 5, S_FIGHT, W_NONE, "start_after_reset");
        frame(1, 0, 5, 4, 0, 1, S_FIGHT, W_NONE, "hit_after_reset");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        if (sb.size() > 0) begin
            checks += sb.size();
            errors += sb.size();
            $display("[TB] FAIL drain: %0d checks still pending, required 0", sb.size());
            sb.delete();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
